sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive video reads granted while write FIFO non-empty.
REQ-002 SHALL have clk  in  1  system clock (50 MHz); all logic on rising edge.
REQ-003 SHALL have reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have fifo_addr  in  17  / fifo_data  in  8: head entry of write FIFO, valid when fifo_empty=0.
REQ-005 SHALL have fifo_empty  in  1 / fifo_rd_en  out  1: FIFO status and pop strobe.
REQ-006 SHALL have vid_req  in  1 / vid_addr  in  17: video read request; requester holds both stable until vid_ack.
REQ-007 SHALL have vid_ack  out  1 / vid_data  out  8 / vid_valid  out  1: grant pulse, read byte, data-valid pulse.
REQ-008 SHALL have sram_addr  out  17 / sram_dq_out  out  8 / sram_dq_oe  out  1 / sram_dq_in  in  8: SRAM bus; tristate pad lives at top level.
REQ-009 SHALL have sram_ce_n, sram_oe_n, sram_we_n  out  1 each: active-low SRAM controls.
REQ-010 SHALL have busy  out  1: high when state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-012 IDLE: read grant when vid_req=1 and (fifo_empty=1 or starve_cnt<STARVE_LIMIT) -> RD_ADDR, latching vid_addr.
REQ-013 IDLE: otherwise if fifo_empty=0 -> WR_SETUP, latching fifo_addr/fifo_data; fifo_rd_en SHALL be high combinationally for exactly that IDLE cycle.
REQ-014 fifo_rd_en SHALL be 0 in every other cycle, including every cycle with reset=1.
REQ-015 Read sequence RD_ADDR -> RD_DATA -> IDLE; write sequence WR_SETUP -> WR_PULSE -> WR_HOLD -> IDLE; no other transitions.
REQ-016 All SRAM outputs, vid_ack, vid_data and vid_valid SHALL be registered (set on the edge entering the state).
REQ-017 RD_ADDR/RD_DATA: sram_addr=latched address, ce_n=0, oe_n=0, we_n=1, dq_oe=0; vid_ack=1 during RD_ADDR only.
REQ-018 sram_dq_in SHALL be captured into vid_data on the edge leaving RD_DATA; vid_valid=1 for one cycle, 2 cycles after the vid_ack cycle.
REQ-019 WR_SETUP/WR_PULSE/WR_HOLD: sram_addr and sram_dq_out = latched entry, dq_oe=1, ce_n=0, oe_n=1; we_n=0 in WR_PULSE only.
REQ-020 IDLE: ce_n=oe_n=we_n=1, dq_oe=0; sram_addr and sram_dq_out hold last values.
REQ-021 starve_cnt: +1 on read grant with fifo_empty=0, saturating at STARVE_LIMIT; cleared on write grant; unchanged on read grant with fifo_empty=1.
REQ-022 STARVE_LIMIT=0 SHALL give writes strict priority whenever FIFO non-empty.
REQ-023 vid_req arriving mid-operation SHALL be evaluated only in next IDLE cycle; no request is dropped while vid_req held.
REQ-024 Throughput: one read per 3 cycles, one write per 4 cycles, back-to-back without extra idle.

Reset
REQ-025 On reset: state=IDLE, starve_cnt=0, sram_addr=0, sram_dq_out=0, dq_oe=0, ce_n=oe_n=we_n=1, vid_data=0, vid_valid=0, vid_ack=0, busy=0.
REQ-026 Reset mid-read SHALL suppress vid_valid; reset mid-write SHALL return we_n=1 and dq_oe=0 next edge; the popped entry is discarded.

Structure
REQ-027 Shared package sram_pkg SHALL hold SRAM_AW=17, SRAM_DW=8 and the state enumeration.
REQ-028 Single module; no sub-module; FIFO and pad instantiated by parent.

Verification
REQ-029 FIFO holds (0x00010,0xA5), no vid_req -> fifo_rd_en one cycle, we_n low exactly one cycle with sram_addr=0x00010, dq_out=0xA5, dq_oe=1.
REQ-030 vid_req addr 0x1FFFF, FIFO empty, SRAM model returns 0x3C -> vid_ack, then vid_valid with vid_data=0x3C 2 cycles later.
REQ-031 vid_req held continuously, 3 FIFO entries, STARVE_LIMIT=4 -> read,read,read,read,write pattern; all 3 writes complete.
REQ-032 Simultaneous vid_req and non-empty FIFO in IDLE with starve_cnt=0 -> read granted first, fifo_rd_en=0 that cycle.
REQ-033 reset asserted in WR_PULSE -> next edge we_n=1, dq_oe=0, busy=0, no further fifo_rd_en until FIFO re-evaluated.
REQ-034 STARVE_LIMIT=0, both requesters active -> every write precedes any read while FIFO non-empty.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared SRAM bus widths and arbiter state encoding.
package sram_pkg;
  localparam int SRAM_AW = 17;
  localparam int SRAM_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;
endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one async SRAM between video reads and a write FIFO; reads win
// until STARVE_LIMIT consecutive reads have been granted over a pending write.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SRAM_AW-1:0] fifo_addr,
  input  logic [SRAM_DW-1:0] fifo_data,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic               vid_req,
  input  logic [SRAM_AW-1:0] vid_addr,
  output logic               vid_ack,
  output logic [SRAM_DW-1:0] vid_data,
  output logic               vid_valid,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               busy
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t             state_q;
  logic [CW-1:0]      starve_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] dout_q;
  logic [SRAM_DW-1:0] vdata_q;
  logic               dq_oe_q, ce_n_q, oe_n_q, we_n_q;
  logic               ack_q, vvalid_q;
  logic               rd_grant, wr_grant;

  // With LIMIT=0 the starve test never passes, so a pending write always wins.
  always_comb begin
    rd_grant = (state_q == ST_IDLE) && vid_req && (fifo_empty || (starve_q < LIMIT));
    wr_grant = (state_q == ST_IDLE) && !rd_grant && !fifo_empty;
  end

  assign fifo_rd_en  = wr_grant && !reset;
  assign busy        = (state_q != ST_IDLE);
  assign vid_ack     = ack_q;
  assign vid_data    = vdata_q;
  assign vid_valid   = vvalid_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dout_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
      vdata_q  <= '0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ack_q    <= 1'b0;
      vvalid_q <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      vvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rd_grant) begin
            state_q <= ST_RD_ADDR;
            addr_q  <= vid_addr;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            ack_q   <= 1'b1;
            if (!fifo_empty && (starve_q < LIMIT)) starve_q <= starve_q + CW'(1);
          end else if (wr_grant) begin
            state_q  <= ST_WR_SETUP;
            addr_q   <= fifo_addr;
            dout_q   <= fifo_data;
            dq_oe_q  <= 1'b1;
            ce_n_q   <= 1'b0;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            starve_q <= '0;
          end
        end
        ST_RD_ADDR: state_q <= ST_RD_DATA;
        ST_RD_DATA: begin
          state_q  <= ST_IDLE;
          vdata_q  <= sram_dq_in;
          vvalid_q <= 1'b1;
          ce_n_q   <= 1'b1;
          oe_n_q   <= 1'b1;
        end
        ST_WR_SETUP: begin
          state_q <= ST_WR_PULSE;
          we_n_q  <= 1'b0;
        end
        ST_WR_PULSE: begin
          state_q <= ST_WR_HOLD;
          we_n_q  <= 1'b1;
        end
        ST_WR_HOLD: begin
          state_q <= ST_IDLE;
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
